// File: rtl/spi_master_pkg.sv
// Shared command/state encodings and default frame geometry for the SPI
// master sequencer.
package spi_master_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        TURN,
        RECV,
        DONE,
        GAP
    } mstr_state_e;

    localparam int FRAME_W_DEF = 10;
    localparam int RD_W_DEF    = 8;

endpackage

// File: rtl/spi_shift_unit.sv
// MOSI parallel-to-serial and MISO serial-to-parallel shift registers.
// Both are MSB-first; a load also clears the receive register.
module spi_shift_unit
    import spi_master_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int RD_W    = RD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift_out,
    input  logic               shift_in,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               miso_bit,
    output logic               mosi_bit,
    output logic [RD_W-1:0]    rx_data
);

    logic [FRAME_W-1:0] tx_reg;
    logic [RD_W-1:0]    rx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_reg <= '0;
            rx_reg <= '0;
        end else begin
            if (load) begin
                tx_reg <= load_data;
            end else if (shift_out) begin
                tx_reg <= {tx_reg[FRAME_W-2:0], 1'b0};
            end

            if (load) begin
                rx_reg <= '0;
            end else if (shift_in) begin
                rx_reg <= {rx_reg[RD_W-2:0], miso_bit};
            end
        end
    end

    assign mosi_bit = tx_reg[FRAME_W-1];
    assign rx_data  = rx_reg;

endmodule

// File: rtl/spi_master_seq.sv
// Sequencing controller: turns RAM requests into SS_n-framed SPI transfers,
// collects the MISO byte for read-data and enforces read-address-before-read-data.
module spi_master_seq
    import spi_master_pkg::*;
#(
    parameter int FRAME_W  = FRAME_W_DEF,
    parameter int RD_W     = RD_W_DEF,
    parameter int TURN_CYC = 1,
    parameter int GAP_CYC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_cmd,
    input  logic [7:0]      req_data,
    output logic            rsp_valid,
    output logic [RD_W-1:0] rsp_data,
    output logic            rsp_err,
    output logic            busy,
    output logic            SS_n,
    output logic            MOSI,
    input  logic            MISO
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(RD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 2) ? GAP_CYC - 3 : 0);
    localparam bit               USE_GAP    = (GAP_CYC > 2);

    mstr_state_e        state;
    mstr_state_e        next_state;
    spi_cmd_e           cmd_q;
    logic               err_q;
    logic               rd_addr_seen;
    logic               ready_en;
    logic [CNT_W-1:0]   cnt;
    logic               hs;
    logic               bad_rd;
    logic               load;
    logic               shift_out;
    logic               shift_in;
    logic [FRAME_W-1:0] load_word;
    logic               mosi_bit;
    logic [RD_W-1:0]    rx_data;
    logic               in_frame;

    assign hs        = req_valid && req_ready;
    assign bad_rd    = (req_cmd == RD_DATA) && !rd_addr_seen;
    assign load_word = FRAME_W'({req_cmd, (req_cmd == RD_DATA) ? 8'h00 : req_data});

    spi_shift_unit #(
        .FRAME_W (FRAME_W),
        .RD_W    (RD_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift_out (shift_out),
        .shift_in  (shift_in),
        .load_data (load_word),
        .miso_bit  (MISO),
        .mosi_bit  (mosi_bit),
        .rx_data   (rx_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // One counter serves every timed state; it restarts on each state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q        <= WR_ADDR;
            err_q        <= 1'b0;
            rd_addr_seen <= 1'b0;
            ready_en     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (hs) begin
                cmd_q <= spi_cmd_e'(req_cmd);
                err_q <= bad_rd;
            end
            if (state == DONE && !err_q) begin
                if (cmd_q == RD_ADDR) begin
                    rd_addr_seen <= 1'b1;
                end else if (cmd_q == RD_DATA) begin
                    rd_addr_seen <= 1'b0;
                end
            end
        end
    end

    // The IDLE cycle holding the next handshake is the final SS_n-high gap
    // cycle, so the GAP state only pads beyond DONE plus that cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift_out  = 1'b0;
        shift_in   = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    load       = 1'b1;
                    next_state = bad_rd ? DONE : START;
                end
            end
            START: begin
                next_state = SHIFT;
            end
            SHIFT: begin
                shift_out = 1'b1;
                if (cnt == SHIFT_LAST) begin
                    next_state = (cmd_q == RD_DATA) ? TURN : DONE;
                end
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    next_state = RECV;
                end
            end
            RECV: begin
                shift_in = 1'b1;
                if (cnt == RECV_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = USE_GAP ? GAP : IDLE;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign in_frame  = (state == START) || (state == SHIFT) || (state == TURN) || (state == RECV);
    assign SS_n      = !in_frame;
    assign MOSI      = ((state == START) || (state == SHIFT)) && mosi_bit;
    assign req_ready = (state == IDLE) && ready_en;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_data  = (rsp_valid && !err_q && cmd_q == RD_DATA) ? rx_data : '0;

endmodule

// File: tb/tb_spi_master_seq.sv
// Self-checking bench for spi_master_seq: a per-cycle frame model plus
// directed literal scenarios and a randomized request stream.
module tb_spi_master_seq;

    localparam int FRAME_W  = 10;
    localparam int RD_W     = 8;
    localparam int TURN_CYC = 1;
    localparam int GAP_CYC  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic [1:0]      req_cmd = 2'b00;
    logic [7:0]      req_data = 8'h00;
    logic            MISO = 1'b0;
    logic            req_ready;
    logic            rsp_valid;
    logic [RD_W-1:0] rsp_data;
    logic            rsp_err;
    logic            busy;
    logic            SS_n;
    logic            MOSI;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    spi_master_seq #(
        .FRAME_W  (FRAME_W),
        .RD_W     (RD_W),
        .TURN_CYC (TURN_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for one cycle, plus the MISO bit the slave drives then.
    typedef struct {
        logic       ss_n;
        logic       mosi;
        logic       ready;
        logic       busy;
        logic       rv;
        logic [7:0] rdata;
        logic       rerr;
        logic       miso;
    } exp_t;

    exp_t       exp_q[$];
    bit         seen_m = 1'b0;
    bit         armed = 1'b0;
    logic [7:0] slave_byte = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t idleEntry(input logic rdy);
        exp_t e;
        e.ss_n  = 1'b1;
        e.mosi  = 1'b0;
        e.ready = rdy;
        e.busy  = 1'b0;
        e.rv    = 1'b0;
        e.rdata = 8'h00;
        e.rerr  = 1'b0;
        e.miso  = 1'($urandom);
        return e;
    endfunction

    // Queue what the wire must show on each cycle after an accepted request.
    task automatic modelRequest(input logic [1:0] cmd, input logic [7:0] data, input logic [7:0] sbyte);
        exp_t e;
        logic [FRAME_W:0] bits;
        int gap_extra;
        e.ss_n  = 1'b0;
        e.mosi  = 1'b0;
        e.ready = 1'b0;
        e.busy  = 1'b1;
        e.rv    = 1'b0;
        e.rdata = 8'h00;
        e.rerr  = 1'b0;
        e.miso  = 1'b0;
        if (cmd == 2'b11 && !seen_m) begin
            e.ss_n = 1'b1;
            e.rv   = 1'b1;
            e.rerr = 1'b1;
            e.miso = 1'($urandom);
            exp_q.push_back(e);
        end else begin
            bits = {cmd[1], cmd, (cmd == 2'b11) ? 8'h00 : data};
            for (int i = FRAME_W; i >= 0; i--) begin
                e.mosi = bits[i];
                e.miso = 1'($urandom);
                exp_q.push_back(e);
            end
            e.mosi = 1'b0;
            if (cmd == 2'b11) begin
                for (int i = 0; i < TURN_CYC; i++) begin
                    e.miso = 1'($urandom);
                    exp_q.push_back(e);
                end
                for (int i = 0; i < RD_W; i++) begin
                    e.miso = sbyte[RD_W-1-i];
                    exp_q.push_back(e);
                end
            end
            e.ss_n  = 1'b1;
            e.rv    = 1'b1;
            e.rdata = (cmd == 2'b11) ? sbyte : 8'h00;
            e.miso  = 1'($urandom);
            exp_q.push_back(e);
            if (cmd == 2'b10) seen_m = 1'b1;
            if (cmd == 2'b11) seen_m = 1'b0;
        end
        gap_extra = (GAP_CYC > 2) ? GAP_CYC - 2 : 0;
        e.ss_n  = 1'b1;
        e.rv    = 1'b0;
        e.rerr  = 1'b0;
        e.rdata = 8'h00;
        for (int i = 0; i < gap_extra; i++) begin
            e.miso = 1'($urandom);
            exp_q.push_back(e);
        end
    endtask

    // Per-cycle compare against the model; also plays the slave on MISO.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                seen_m = 1'b0;
                armed  = 1'b0;
                e = idleEntry(1'b0);
                e.miso = 1'b0;
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = idleEntry(armed);
                armed = 1'b1;
            end
            checkOutput("ss_n", SS_n, e.ss_n);
            checkOutput("mosi", MOSI, e.mosi);
            checkOutput("req_ready", req_ready, e.ready);
            checkOutput("busy", busy, e.busy);
            checkOutput("rsp_valid", rsp_valid, e.rv);
            if (e.rv || rst) begin
                checkOutput("rsp_data", rsp_data, e.rdata);
                checkOutput("rsp_err", rsp_err, e.rerr);
            end
            MISO = e.miso;
            if (!rst && e.ready && req_valid) begin
                modelRequest(req_cmd, req_data, slave_byte);
            end
        end
    end

    // Call and return at posedge+1; returns in the cycle after the handshake.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [7:0] data, input bit hold, output int hs_cyc);
        bit hs;
        int n;
        req_cmd   = cmd;
        req_data  = data;
        req_valid = 1'b1;
        hs = 1'b0;
        n  = 0;
        hs_cyc = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = req_ready;
            hs_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("handshake_timeout", hs, 1);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic measureFrame(output int lat, output int ss_low, output logic [15:0] mosi_bits,
                                output logic [7:0] rdata, output logic rerr);
        bit done;
        lat = 0;
        ss_low = 0;
        mosi_bits = 16'h0000;
        rdata = 8'h00;
        rerr = 1'b0;
        done = 1'b0;
        while (!done && lat < 60) begin
            lat++;
            @(negedge clk);
            if (!SS_n) begin
                ss_low++;
                mosi_bits = {mosi_bits[14:0], MOSI};
            end
            if (rsp_valid) begin
                done  = 1'b1;
                rdata = rsp_data;
                rerr  = rsp_err;
            end
        end
        checkOutput("rsp_timeout", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hs1, hs2, lat, ss_low, n;
        logic [15:0] mbits;
        logic [7:0] rd;
        logic re;
        logic [1:0] c;
        bit hold;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ss_n", SS_n, 1);
        checkOutput("reset_mosi", MOSI, 0);
        checkOutput("reset_ready", req_ready, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", req_ready, 1);

        $display("[TB] illegal RD_DATA after reset");
        applyStimulus(2'b11, 8'hFF, 1'b0, hs1);
        measureFrame(lat, ss_low, mbits, rd, re);
        checkOutput("illegal_rd_latency", lat, 1);
        checkOutput("illegal_rd_err", re, 1);
        checkOutput("illegal_rd_ss_low", ss_low, 0);

        $display("[TB] WR_ADDR 0x3C");
        applyStimulus(2'b00, 8'h3C, 1'b0, hs1);
        measureFrame(lat, ss_low, mbits, rd, re);
        checkOutput("wr_addr_latency", lat, 12);
        checkOutput("wr_addr_ss_low", ss_low, 11);
        checkOutput("wr_addr_mosi", mbits, 16'h003C);
        checkOutput("wr_addr_rdata", rd, 0);
        checkOutput("wr_addr_err", re, 0);

        $display("[TB] read pair");
        applyStimulus(2'b10, 8'h3C, 1'b0, hs1);
        measureFrame(lat, ss_low, mbits, rd, re);
        checkOutput("rd_addr_latency", lat, 12);
        checkOutput("rd_addr_mosi", mbits, 16'h063C);
        slave_byte = 8'hA5;
        applyStimulus(2'b11, 8'h77, 1'b0, hs1);
        measureFrame(lat, ss_low, mbits, rd, re);
        checkOutput("rd_data_latency", lat, 21);
        checkOutput("rd_data_ss_low", ss_low, 20);
        checkOutput("rd_data_value", rd, 8'hA5);
        checkOutput("rd_data_err", re, 0);

        $display("[TB] second RD_DATA");
        applyStimulus(2'b11, 8'h00, 1'b0, hs1);
        measureFrame(lat, ss_low, mbits, rd, re);
        checkOutput("second_rd_latency", lat, 1);
        checkOutput("second_rd_err", re, 1);
        checkOutput("second_rd_ss_low", ss_low, 0);

        $display("[TB] back-to-back WR_DATA");
        applyStimulus(2'b01, 8'h5A, 1'b1, hs1);
        applyStimulus(2'b01, 8'hC3, 1'b0, hs2);
        checkOutput("b2b_spacing", hs2 - hs1, 13);
        repeat (20) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] reset mid-frame");
        applyStimulus(2'b01, 8'h96, 1'b0, hs1);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("frame_active_before_rst", SS_n, 0);
        rst = 1'b1;
        #1;
        checkOutput("abort_ss_n", SS_n, 1);
        checkOutput("abort_mosi", MOSI, 0);
        checkOutput("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        checkOutput("no_rsp_after_abort", n, 0);
        checkOutput("ready_after_abort", req_ready, 1);
        @(posedge clk);
        #1;

        $display("[TB] randomized requests");
        for (int k = 0; k < 80; k++) begin
            slave_byte = 8'($urandom);
            c = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0);
            applyStimulus(c, 8'($urandom), hold, hs1);
            if (!hold) begin
                repeat ($urandom_range(0, 4)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        req_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
